// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns core load/store requests into word-wide bus transactions
// with byte lanes, store replication, load extension, stall generation and timeout abort.
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_memop,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [3:0]       be_q, be_d;
  logic             we_q, we_d;
  logic             err_q, err_d;
  logic [2:0]       op_q, op_d;
  logic [1:0]       lane_q, lane_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       op_n;
  logic             is_byte, is_half;
  logic             accept, timeout;
  logic [3:0]       be_calc;
  logic [31:0]      wd_calc;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_ext;

  // Unsupported MemOp codes behave as a plain word access.
  always_comb begin
    case (cpu_memop)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_n = cpu_memop;
      default:                                op_n = 3'b010;
    endcase
  end

  assign is_byte  = (op_n[1:0] == 2'b00);
  assign is_half  = (op_n[1:0] == 2'b01);
  assign misalign = cpu_req & ((is_half & cpu_addr[0]) |
                               (~is_byte & ~is_half & (cpu_addr[1:0] != 2'b00)));

  // Handshake: bus_req is held with stable addr/be/we/wdata until the cycle bus_ack is
  // sampled high (transfer completes) or the timeout abort; bus_ack is ignored otherwise.
  assign accept  = (state_q == S_IDLE) & cpu_req & ~misalign;
  assign timeout = (state_q == S_BUSY) & ~bus_ack & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    be_calc = 4'b1111;
    wd_calc = cpu_wdata;
    if (is_byte) begin
      be_calc = 4'b0001 << cpu_addr[1:0];
      wd_calc = {4{cpu_wdata[7:0]}};
    end else if (is_half) begin
      be_calc = cpu_addr[1] ? 4'b1100 : 4'b0011;
      wd_calc = {2{cpu_wdata[15:0]}};
    end
  end

  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = bus_rdata[7:0];
      2'd1:    ld_byte = bus_rdata[15:8];
      2'd2:    ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (op_q[1:0])
      2'b00:   ld_ext = {{24{~op_q[2] & ld_byte[7]}}, ld_byte};
      2'b01:   ld_ext = {{16{~op_q[2] & ld_half[15]}}, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_BUSY;
      S_BUSY:  if (bus_ack || timeout) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    op_d    = op_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (accept) begin
      addr_d  = {cpu_addr[31:2], 2'b00};
      wdata_d = wd_calc;
      be_d    = be_calc;
      we_d    = cpu_we;
      op_d    = op_n;
      lane_d  = cpu_addr[1:0];
      cnt_d   = '0;
    end
    if (state_q == S_BUSY) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (bus_ack) begin
        if (!we_q) rdata_d = ld_ext;
      end else if (timeout) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end
    end
  end

  always_comb begin
    bus_req = (state_q == S_BUSY);
    stall   = (state_q == S_BUSY) | accept;
  end

  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_we    = we_q;
  assign bus_wdata = wdata_q;
  assign bus_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= 3'b010;
      lane_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
      op_q    <= op_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
